// File: rtl/step_seq_pkg.sv
// Shared definitions for the control-step sequencer: state encoding and default step count.
package step_seq_pkg;

   localparam int STEPS_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

endpackage : step_seq_pkg

// File: rtl/step_decode.sv
// Binary step index to one-hot step vector (bit idx_i set, all others clear).
module step_decode #(
   parameter int STEPS  = step_seq_pkg::STEPS_DEFAULT,
   parameter int STEP_W = $clog2(STEPS)
) (
   input  logic [STEP_W-1:0] idx_i,
   output logic [STEPS-1:0]  onehot_o
);

   localparam logic [STEPS-1:0] ONE = {{(STEPS-1){1'b0}}, 1'b1};

   // Shift a single set bit up to the requested step position.
   always_comb begin
      onehot_o = ONE << idx_i;
   end

endmodule : step_decode

// File: rtl/step_sequencer.sv
// Instruction control-step sequencer: walks T0..T(STEPS-1) with stall, early end,
// halt-at-boundary and abort, counting completed instructions.
module step_sequencer
   import step_seq_pkg::*;
#(
   parameter int STEPS  = STEPS_DEFAULT,
   localparam int STEP_W = $clog2(STEPS)
) (
   input  logic              iClk,
   input  logic              nRst,
   input  logic              iStart,
   input  logic              iStall,
   input  logic              iEnd,
   input  logic              iHalt,
   input  logic              iClear,
   output logic [STEPS-1:0]  oStep,
   output logic [STEP_W-1:0] oStepIdx,
   output logic              oBusy,
   output logic              oDone,
   output logic              oHalted,
   output logic [31:0]       oInsCnt
);

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

   state_t             state_q, state_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic [STEPS-1:0]   step_oh_q, step_oh_d;
   logic [STEPS-1:0]   step_dec;
   logic               halt_pend_q, halt_pend_d;
   logic               done_q, done_d;
   logic [31:0]        ins_cnt_q, ins_cnt_d;

   // The one-hot step is decoded from the next index so oStep comes straight from a flop.
   step_decode #(
      .STEPS (STEPS)
   ) u_step_decode (
      .idx_i    (step_d),
      .onehot_o (step_dec)
   );

   // Next-state: abort first, then stall hold, then instruction end, then step advance.
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      halt_pend_d = halt_pend_q;
      done_d      = 1'b0;
      ins_cnt_d   = ins_cnt_q;

      if (iClear) begin
         state_d     = ST_IDLE;
         step_d      = '0;
         halt_pend_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               halt_pend_d = 1'b0;
               step_d      = '0;
               if (iHalt) begin
                  state_d = ST_HALT;
               end else if (iStart) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (iStall) begin
                  // Everything holds; iEnd is not looked at while stalled.
               end else if (iEnd || (step_q == LAST_STEP)) begin
                  done_d      = 1'b1;
                  ins_cnt_d   = ins_cnt_q + 32'd1;
                  step_d      = '0;
                  halt_pend_d = 1'b0;
                  if (halt_pend_q || iHalt) begin
                     state_d = ST_HALT;
                  end else if (iStart) begin
                     state_d = ST_RUN;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  step_d = step_q + 1'b1;
                  if (iHalt) begin
                     halt_pend_d = 1'b1;
                  end
               end
            end
            ST_HALT: begin
               step_d      = '0;
               halt_pend_d = 1'b0;
            end
            default: begin
               state_d     = ST_IDLE;
               step_d      = '0;
               halt_pend_d = 1'b0;
            end
         endcase
      end

      step_oh_d = (state_d == ST_RUN) ? step_dec : '0;
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge iClk) begin
      if (!nRst) begin
         state_q     <= ST_IDLE;
         step_q      <= '0;
         step_oh_q   <= '0;
         halt_pend_q <= 1'b0;
         done_q      <= 1'b0;
         ins_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         step_oh_q   <= step_oh_d;
         halt_pend_q <= halt_pend_d;
         done_q      <= done_d;
         ins_cnt_q   <= ins_cnt_d;
      end
   end

   assign oStep    = step_oh_q;
   assign oStepIdx = step_q;
   assign oBusy    = (state_q == ST_RUN);
   assign oHalted  = (state_q == ST_HALT);
   assign oDone    = done_q;
   assign oInsCnt  = ins_cnt_q;

endmodule : step_sequencer

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with STEPS=8.
module tb_step_sequencer;

   logic        iClk = 1'b0;
   logic        nRst;
   logic        iStart, iStall, iEnd, iHalt, iClear;
   logic [7:0]  oStep;
   logic [2:0]  oStepIdx;
   logic        oBusy, oDone, oHalted;
   logic [31:0] oInsCnt;

   int checks = 0;
   int errors = 0;

   step_sequencer #(.STEPS(8)) dut (
      .iClk     (iClk),
      .nRst     (nRst),
      .iStart   (iStart),
      .iStall   (iStall),
      .iEnd     (iEnd),
      .iHalt    (iHalt),
      .iClear   (iClear),
      .oStep    (oStep),
      .oStepIdx (oStepIdx),
      .oBusy    (oBusy),
      .oDone    (oDone),
      .oHalted  (oHalted),
      .oInsCnt  (oInsCnt)
   );

   always #5 iClk = ~iClk;

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_run(input string tag, input int idx, input logic done_exp);
      logic [7:0] oh;
      oh = 8'd1 << idx;
      chk({tag, "_idx"}, {29'd0, oStepIdx}, idx);
      chk({tag, "_step"}, {24'd0, oStep}, {24'd0, oh});
      chk({tag, "_busy"}, {31'd0, oBusy}, 32'd1);
      chk({tag, "_done"}, {31'd0, oDone}, {31'd0, done_exp});
   endtask

   task automatic chk_idle(input string tag, input logic done_exp, input logic halted_exp, input logic [31:0] cnt_exp);
      chk({tag, "_busy"}, {31'd0, oBusy}, 32'd0);
      chk({tag, "_step"}, {24'd0, oStep}, 32'd0);
      chk({tag, "_idx"}, {29'd0, oStepIdx}, 32'd0);
      chk({tag, "_done"}, {31'd0, oDone}, {31'd0, done_exp});
      chk({tag, "_halted"}, {31'd0, oHalted}, {31'd0, halted_exp});
      chk({tag, "_cnt"}, oInsCnt, cnt_exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      nRst = 1'b0; iStart = 1'b0; iStall = 1'b0; iEnd = 1'b0; iHalt = 1'b0; iClear = 1'b0;
      tick(); tick();
      chk_idle("reset", 1'b0, 1'b0, 32'd0);
      nRst = 1'b1;

      // Full instruction T0..T7.
      iStart = 1'b1; tick(); iStart = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk_run("full", i, 1'b0);
         tick();
      end
      chk_idle("full_end", 1'b1, 1'b0, 32'd1);
      tick();
      chk({"full_done_once"}, {31'd0, oDone}, 32'd0);

      // Early end at step 4.
      iStart = 1'b1; tick(); iStart = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk_run("early", i, 1'b0);
         if (i == 4) iEnd = 1'b1;
         tick();
      end
      iEnd = 1'b0;
      chk_idle("early_end", 1'b1, 1'b0, 32'd2);

      // Stall at step 2 with iEnd high.
      iStart = 1'b1; tick(); iStart = 1'b0;
      tick(); tick();
      chk_run("stall_pre", 2, 1'b0);
      iStall = 1'b1; iEnd = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_run("stall_hold", 2, 1'b0);
      end
      iStall = 1'b0;
      tick();
      iEnd = 1'b0;
      chk_idle("stall_end", 1'b1, 1'b0, 32'd3);

      // Back-to-back with iStart held high.
      iStart = 1'b1; tick();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 8; i++) begin
            chk_run("b2b", i, (i == 0 && k == 1));
            if (k == 1 && i == 7) iStart = 1'b0;
            tick();
         end
      end
      chk_idle("b2b_end", 1'b1, 1'b0, 32'd5);

      // Halt request at step 1 is honoured at the boundary.
      iStart = 1'b1; tick(); iStart = 1'b0;
      chk_run("halt", 0, 1'b0);
      tick();
      chk_run("halt", 1, 1'b0);
      iHalt = 1'b1; tick(); iHalt = 1'b0;
      chk_run("halt_pend", 2, 1'b0);
      for (int i = 3; i < 8; i++) tick();
      chk_run("halt_last", 7, 1'b0);
      tick();
      chk_idle("halt_enter", 1'b1, 1'b1, 32'd6);
      iStart = 1'b1; tick(); tick();
      chk_idle("halt_ignore_start", 1'b0, 1'b1, 32'd6);
      iStart = 1'b0; iClear = 1'b1; tick(); iClear = 1'b0;
      chk_idle("halt_clear", 1'b0, 1'b0, 32'd6);

      // Start and halt together in IDLE: halt wins.
      iStart = 1'b1; iHalt = 1'b1; tick(); iStart = 1'b0; iHalt = 1'b0;
      chk_idle("idle_halt_wins", 1'b0, 1'b1, 32'd6);
      iClear = 1'b1; tick(); iClear = 1'b0;

      // Abort mid-instruction: no done, count unchanged.
      iStart = 1'b1; tick(); iStart = 1'b0;
      tick();
      iClear = 1'b1; tick(); iClear = 1'b0;
      chk_idle("abort", 1'b0, 1'b0, 32'd6);

      // Reset at step 3 overrides a held start.
      iStart = 1'b1; tick(); iStart = 1'b0;
      tick(); tick(); tick();
      chk_run("rst_pre", 3, 1'b0);
      nRst = 1'b0; iStart = 1'b1; iEnd = 1'b1; tick();
      chk_idle("rst_mid", 1'b0, 1'b0, 32'd0);
      nRst = 1'b1; iStart = 1'b0; iEnd = 1'b0; tick();
      chk_idle("rst_after", 1'b0, 1'b0, 32'd0);

      // Counter wrap from all-ones.
      force dut.ins_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.ins_cnt_q;
      #1;
      chk("wrap_preload", oInsCnt, 32'hFFFF_FFFF);
      iStart = 1'b1; tick(); iStart = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk_idle("wrap", 1'b1, 1'b0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_step_sequencer
